// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/step controller and the display logic that
// decodes its state and mode onto HEX/LEDR.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_HALT  = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back to the old value restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run/step controller for the multicycle processor: stretched processor
// reset, per-cycle clock enable for run/step/burst/halt, and a cycle counter.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_reset,
    input  logic             btn_step,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             cpu_reset,
    output logic             cpu_clk_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             rst_rise;
    logic             step_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clock (clock),
        .reset (reset),
        .raw   (btn_reset),
        .level (),
        .rise  (rst_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clock (clock),
        .reset (reset),
        .raw   (btn_step),
        .level (),
        .rise  (step_rise)
    );

    // Outputs are computed for the state being entered, so cpu_clk_en and
    // busy change on the same edge as the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_RST;
            rem         <= CNT_W'(RESET_CYCLES);
            cpu_reset   <= 1'b1;
            cpu_clk_en  <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b1;
        end else if (rst_rise) begin
            state       <= ST_RST;
            rem         <= CNT_W'(RESET_CYCLES);
            cpu_reset   <= 1'b1;
            cpu_clk_en  <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b1;
        end else begin
            if (cpu_clk_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
            case (state)
                ST_RST: begin
                    cpu_clk_en <= 1'b0;
                    if (rem == CNT_W'(1)) begin
                        cpu_reset <= 1'b0;
                        busy      <= 1'b0;
                        if (mode == MODE_RUN) begin
                            state      <= ST_RUN;
                            cpu_clk_en <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                ST_IDLE: begin
                    cpu_clk_en <= 1'b0;
                    if (mode == MODE_RUN) begin
                        state      <= ST_RUN;
                        cpu_clk_en <= 1'b1;
                    end else if (mode == MODE_STEP && step_rise) begin
                        cpu_clk_en <= 1'b1;
                    end else if (mode == MODE_BURST && step_rise && burst_len != '0) begin
                        state      <= ST_BURST;
                        rem        <= burst_len;
                        cpu_clk_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mode != MODE_RUN) begin
                        state      <= ST_IDLE;
                        cpu_clk_en <= 1'b0;
                    end else begin
                        cpu_clk_en <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (rem == CNT_W'(1)) begin
                        state      <= ST_IDLE;
                        cpu_clk_en <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        rem        <= rem - 1'b1;
                        cpu_clk_en <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_RST;
                    rem        <= CNT_W'(RESET_CYCLES);
                    cpu_reset  <= 1'b1;
                    cpu_clk_en <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run/step controller between the DE2 board inputs (KEY/SW) and the multicycle processor. It generates a stretched processor reset and a per-cycle clock enable, replacing the free-running clock plus raw reset pulse used at bring-up. It supports four modes: free-run, single-step, N-cycle burst and halt. Raw pushbuttons are debounced internally, and the block counts executed processor cycles for HEX display.

## Interface
- RESET_CYCLES, default 4: cycles `cpu_reset` is held after any reset event (≥1).
- DEBOUNCE_CYCLES, default 8: consecutive stable synchronized samples needed to accept a button change (≥1).
- CNT_W, default 16: width of `burst_len` and `cycle_count`.
- `clock` in 1: single system clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high; resets the block and forces `cpu_reset`.
- `btn_reset` in 1: raw async pushbutton, active-high request to re-reset the processor.
- `btn_step` in 1: raw async pushbutton, active-high step/burst trigger.
- `mode` in 2: 00 RUN, 01 STEP, 10 BURST, 11 HALT; quasi-static, no synchronizer.
- `burst_len` in CNT_W: enables per BURST trigger; sampled at the trigger.
- `cpu_reset` out 1: active-high reset to the processor.
- `cpu_clk_en` out 1: processor advances one cycle in each cycle where this is high.
- `cycle_count` out CNT_W: number of `cpu_clk_en` pulses since the last reset event.
- `busy` out 1: high in the RST and BURST states.

## Operation
- **States.** RST, IDLE, RUN, BURST. The state register, a down-counter `rem` (CNT_W bits) and all outputs are registered.
- **Reset values.** `reset=1` gives state=RST, `rem`=RESET_CYCLES, `cpu_reset`=1, `cpu_clk_en`=0, `cycle_count`=0, `busy`=1, and debouncer stable levels=0.
- **RST.**
  - `cpu_reset`=1 and `cpu_clk_en`=0; decrement `rem`.
  - When `rem`==1, the next state is RUN if `mode`=00, otherwise IDLE.
  - `cpu_reset` falls on the same edge as the state exit.
- **IDLE.**
  - `mode`=00 → RUN.
  - STEP with a debounced `btn_step` rise → one `cpu_clk_en` next cycle; stay IDLE.
  - BURST with a rise and `burst_len`≠0 → BURST, `rem`=`burst_len`.
  - BURST with a rise and `burst_len`=0 is ignored.
  - HALT: no action.
- **RUN.** `cpu_clk_en`=1 every cycle. When `mode`≠00, `cpu_clk_en` is 0 from the next cycle and the state goes to IDLE.
- **BURST.**
  - `cpu_clk_en`=1 for exactly `rem` cycles, then IDLE.
  - `mode` and `btn_step` are ignored until the burst is done.
- **Reset event.** A debounced `btn_reset` rise in any state → RST, `rem`=RESET_CYCLES, `cycle_count`=0, and any burst is aborted.
  - `reset` takes precedence over `btn_reset`.
  - `btn_reset` takes precedence over a simultaneous step rise.
- **`cycle_count`.** Increments by 1 on each cycle `cpu_clk_en`=1 and wraps modulo 2^CNT_W without saturation.
- **Debouncer.**
  - Two-flop synchronizer followed by a counter of cycles where the synchronized value differs from the stable level.
  - The counter clears whenever the values match.
  - When the count reaches DEBOUNCE_CYCLES the stable level toggles.
  - A 1-cycle `rise` pulse is emitted on each 0→1 toggle; falls produce no pulse.
  - Holding the button produces exactly one rise.

## Timing
- **Processor reset.** `cpu_reset` is high for exactly RESET_CYCLES cycles after the `reset` deassert edge.
- **Button latency.** Raw button edge → `rise` after 2+DEBOUNCE_CYCLES clock edges.
- **Step/burst enable.** `rise` → first `cpu_clk_en` on the next cycle (registered).
- **BURST.** The `cpu_clk_en` high run is contiguous and exactly `burst_len` cycles.
- **Return to IDLE.** `busy` drops on the same edge that `cpu_clk_en` drops.
- **RUN exit.** A `mode` change out of RUN produces at most 1 further enable (the cycle in which `mode` changed).
- **Glitch rejection.** A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never produces a `rise`.
- **Mid-operation reset.** `reset` asserted mid-burst sets `cpu_clk_en`=0 and `cpu_reset`=1 on the next edge.

## Structure
- **Shared package.** `run_ctrl_pkg` holds the state encoding (RST=0, IDLE=1, RUN=2, BURST=3) and the mode constants (MODE_RUN, MODE_STEP, MODE_BURST, MODE_HALT). The HEX/LEDR display logic imports these.
- **Sub-module.** `btn_debounce` (parameter DEBOUNCE_CYCLES; ports `clock`, `reset`, `raw`, `level`, `rise`) is instantiated twice.
- **Top level.** The FSM, `rem` counter and `cycle_count` live in `run_ctrl`.

## Test plan
- **Reset release.** RESET_CYCLES=4, `mode`=00: `reset` high 3 cycles then low → `cpu_reset`=1 for 4 cycles, then `cpu_clk_en`=1 continuously, and `cycle_count`=10 after 10 enabled cycles.
- **Single step.** STEP, DEBOUNCE_CYCLES=8, `btn_step` high 50 cycles → exactly one `cpu_clk_en`, 11 edges after the press, and `cycle_count`=1. A 5-cycle glitch produces no enable.
- **Burst.** BURST, `burst_len`=7 → 7 contiguous enables and `busy` high throughout. A second press mid-burst is ignored (count=7). With `burst_len`=0 the press produces no enable.
- **Reset mid-burst.** `btn_reset` press during a `burst_len`=100 burst → enables stop, `cpu_reset` high 4 cycles, `cycle_count`=0, then IDLE (mode=10).
- **Mode change.** RUN→HALT mid-run → at most one further enable, then none for 20 cycles. HALT→RUN resumes enables the next cycle.
- **Counter wrap.** CNT_W=4, RUN for 17 enabled cycles → `cycle_count`=1.
